// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side signal bundle: the scanner (master) drives the columns and key outputs,
// the keypad/consumer side (slave) supplies the rows.
interface hex_keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] entry;

  modport master (
    input  row,
    output col,
    output key_valid,
    output key_code,
    output key_held,
    output entry
  );

  modport slave (
    output row,
    input  col,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  entry
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low column, samples synchronized rows and
// debounces single-key presses across whole scans, shifting accepted digits into entry.
module hex_keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic                  clk,
  input logic                  reset,
  hex_keypad_scanner_if.master kp
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

  // Key codes indexed by press-vector bit 4*col + row, index 15 in the top nibble.
  localparam logic [63:0] CodeMap = {4'hD, 4'hC, 4'hB, 4'hA,
                                     4'hE, 4'h9, 4'h6, 4'h3,
                                     4'hF, 4'h8, 4'h5, 4'h2,
                                     4'h0, 4'h7, 4'h4, 4'h1};

  typedef enum logic [1:0] {StReleased, StPressWait, StHeld, StReleaseWait} state_e;

  logic [3:0]        row_meta_q, row_sync_q;
  logic [DwellW-1:0] dwell_q;
  logic [1:0]        col_idx_q;
  logic [3:0]        col_q;
  logic [11:0]       press_q;
  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        cand_q;
  logic              key_valid_q;
  logic [3:0]        key_code_q;
  logic              key_held_q;
  logic [15:0]       entry_q;

  logic              sample;
  logic              scan_done;
  logic [3:0]        row_hit;
  logic [15:0]       scan_vec;
  logic              is_none;
  logic              is_single;
  logic [3:0]        hit_idx;
  logic [CntW-1:0]   cnt_inc;
  logic              cnt_full;
  logic [3:0]        cand_code;

  always_comb begin
    sample    = (dwell_q == DwellW'(SCAN_DIV - 1));
    scan_done = sample && (col_idx_q == 2'd3);
    row_hit   = ~row_sync_q;
    // Column 3 is never stored; its rows complete the vector in the sampling cycle.
    scan_vec  = {row_hit, press_q};
    is_none   = (scan_vec == 16'h0000);
    is_single = !is_none && ((scan_vec & (scan_vec - 16'd1)) == 16'h0000);
    hit_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_vec[i]) hit_idx = 4'(i);
    end
    cnt_inc   = cnt_q + 1'b1;
    cnt_full  = (cnt_inc == CntW'(DEBOUNCE_SCANS));
    cand_code = CodeMap[{cand_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      press_q     <= '0;
      state_q     <= StReleased;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      entry_q     <= 16'h0000;
    end else begin
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      key_valid_q <= 1'b0;

      if (sample) begin
        dwell_q   <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= ~(4'b0001 << (col_idx_q + 2'd1));
        if (col_idx_q != 2'd3) begin
          press_q[{col_idx_q, 2'b00} +: 4] <= row_hit;
        end
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end

      if (scan_done) begin
        unique case (state_q)
          StReleased: begin
            if (is_single) begin
              state_q <= StPressWait;
              cand_q  <= hit_idx;
              cnt_q   <= CntW'(1);
            end
          end
          StPressWait: begin
            if (is_single && (hit_idx == cand_q)) begin
              if (cnt_full) begin
                state_q     <= StHeld;
                cnt_q       <= '0;
                key_valid_q <= 1'b1;
                key_code_q  <= cand_code;
                entry_q     <= {entry_q[11:0], cand_code};
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // No restart with a different key in the same scan.
              state_q <= StReleased;
              cnt_q   <= '0;
            end
          end
          StHeld: begin
            if (is_none) begin
              state_q <= StReleaseWait;
              cnt_q   <= CntW'(1);
            end
          end
          StReleaseWait: begin
            if (is_none) begin
              if (cnt_full) begin
                state_q    <= StReleased;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StHeld;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.col       = col_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;
  assign kp.entry     = entry_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a keypad model answers the expected column, and
// expected pulses / held levels are queued per scan and compared when their cycle arrives.
module tb_hex_keypad_scanner;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned Deb     = 3;
  localparam int          ScanLen = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  hex_keypad_scanner_if kp ();

  hex_keypad_scanner #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_SCANS (Deb)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [3:0]  code;
    logic [15:0] entry;
  } pulse_t;

  typedef struct {
    int   k;
    logic v;
  } held_t;

  pulse_t pulse_q[$];
  held_t  held_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     k        = 0;  // cycles since reset release; cycle 0 is the first dwell cycle

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, k);
    end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[4 * c + r] = 1'b1;
    return m;
  endfunction

  task automatic expect_pulse(input int s, input logic [3:0] code, input logic [15:0] entry);
    pulse_t p;
    p.k     = ScanLen * (s + 1);
    p.code  = code;
    p.entry = entry;
    pulse_q.push_back(p);
  endtask

  task automatic expect_held(input int s, input logic v);
    held_t h;
    h.k = ScanLen * (s + 1);
    h.v = v;
    held_q.push_back(h);
  endtask

  // Starts and ends at a falling edge; one clock cycle of keypad behaviour plus monitoring.
  task automatic tick(input logic [15:0] keys);
    int         idx;
    logic [3:0] r_drv;
    logic [3:0] exp_col;
    pulse_t     p;
    held_t      h;
    idx = (k / 4) % 4;
    for (int r = 0; r < 4; r++) r_drv[r] = ~keys[4 * idx + r];
    kp.row  = r_drv;
    exp_col = ~(4'b0001 << idx);
    check_eq("col", kp.col, exp_col);

    if (kp.key_valid) begin
      if (pulse_q.size() == 0) begin
        check_eq("spurious_valid", kp.key_valid, 0);
      end else begin
        p = pulse_q.pop_front();
        check_eq("valid_cycle", k, p.k);
        check_eq("key_code", kp.key_code, p.code);
        check_eq("entry", kp.entry, p.entry);
      end
    end else if (pulse_q.size() != 0 && pulse_q[0].k <= k) begin
      p = pulse_q.pop_front();
      check_eq("missing_valid", kp.key_valid, 1);
    end

    while (held_q.size() != 0 && held_q[0].k <= k) begin
      h = held_q.pop_front();
      check_eq("key_held", kp.key_held, h.v);
    end

    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] keys);
    repeat (ScanLen) tick(keys);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_eq("rst_col", kp.col, 4'b1110);
    check_eq("rst_valid", kp.key_valid, 0);
    check_eq("rst_code", kp.key_code, 0);
    check_eq("rst_held", kp.key_held, 0);
    check_eq("rst_entry", kp.entry, 0);
    check_eq("pending_at_reset", pulse_q.size() + held_q.size(), 0);
    pulse_q.delete();
    held_q.delete();
    reset = 1'b0;
    k     = 0;
  endtask

  task automatic press_release(input logic [15:0] m, input int n_press, input int n_rel,
                               input logic [3:0] code, input logic [15:0] entry);
    int s0;
    s0 = k / ScanLen;
    expect_pulse(s0 + Deb - 1, code, entry);
    expect_held(s0 + Deb - 1, 1'b1);
    expect_held(s0 + n_press + Deb - 2, 1'b1);
    expect_held(s0 + n_press + Deb - 1, 1'b0);
    repeat (n_press) scan(m);
    repeat (n_rel) scan(16'h0000);
  endtask

  initial begin
    int s0;
    logic [15:0] m;
    kp.row = 4'hF;

    // Reset and idle scanning
    do_reset(3);
    scan(16'h0000);
    scan(16'h0000);

    // Clean press and release of key 6
    press_release(key(1, 2), 5, Deb, 4'h6, 16'h0006);

    // Entry shift
    press_release(key(0, 0), 3, Deb, 4'h1, 16'h0061);
    press_release(key(0, 1), 3, Deb, 4'h2, 16'h0612);
    press_release(key(0, 2), 3, Deb, 4'h3, 16'h6123);
    press_release(key(0, 3), 3, Deb, 4'hA, 16'h123A);
    press_release(key(1, 1), 3, Deb, 4'h5, 16'h23A5);

    // Bouncing press, then bouncing release
    s0 = k / ScanLen;
    m  = key(2, 2);
    expect_pulse(s0 + 5, 4'h9, 16'h3A59);
    expect_held(s0 + 5, 1'b1);
    expect_held(s0 + 7, 1'b1);
    expect_held(s0 + 9, 1'b1);
    expect_held(s0 + 10, 1'b0);
    scan(m); scan(m); scan(16'h0000); scan(m); scan(m); scan(m);
    scan(16'h0000); scan(m); scan(16'h0000); scan(16'h0000); scan(16'h0000);

    // Multi-key, then one key released
    repeat (6) scan(key(0, 0) | key(0, 1));
    press_release(key(0, 0), 3, Deb, 4'h1, 16'hA591);

    // Reset in PRESS_WAIT with two agreeing scans
    m = key(3, 3);
    scan(m);
    scan(m);
    repeat (8) tick(m);
    do_reset(2);
    press_release(m, 3, Deb, 4'hD, 16'h000D);
    scan(16'h0000);

    check_eq("pending_end", pulse_q.size() + held_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
